// File: rtl/pe_stream_sink.sv
// Collects per-lane PE results into an AXI4-Stream through a small beat FIFO.
// Define PE_SINK_STATS_EN to build the packet/beat counters; otherwise they read as zero.
module pe_stream_sink #(
  parameter  int FIFO_DEPTH  = 4,
  localparam int PHIT_SIZE   = 512,
  localparam int SIMD_DEGREE = 16,
  localparam int LANE_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PHIT_SIZE-1:0]   i_PE_data,
  input  logic [SIMD_DEGREE-1:0] i_PE_tvalid,
  input  logic [SIMD_DEGREE-1:0] i_PE_tlast,
  input  logic                   i_clr_ovf,
  output logic [PHIT_SIZE-1:0]   m_axis_tdata,
  output logic [PHIT_SIZE/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   o_overflow,
  output logic [15:0]            o_pkt_cnt,
  output logic [15:0]            o_beat_cnt
);

  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;
  localparam int BYTES_PER_LANE = LANE_WIDTH / 8;

  typedef enum logic {IDLE, PKT} stateType;

  stateType state, nextState;

  logic [PHIT_SIZE/8-1:0] beatKeep;
  logic                   beatLast;
  logic                   beatPresent;
  logic                   fifoEmpty;
  logic                   fifoFull;
  logic                   doPop;
  logic                   doPush;
  logic                   doDrop;

  logic [PTR_W-1:0]       wrPtr;
  logic [PTR_W-1:0]       rdPtr;
  logic [CNT_W-1:0]       occupancy;

  logic [PHIT_SIZE-1:0]   dataMem [FIFO_DEPTH];
  logic [PHIT_SIZE/8-1:0] keepMem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  lastMem;

  // Each lane's valid bit enables the four bytes of that lane.
  always_comb begin
    beatKeep = '0;
    for (int k = 0; k < SIMD_DEGREE; k++) begin
      beatKeep[k*BYTES_PER_LANE +: BYTES_PER_LANE] = {BYTES_PER_LANE{i_PE_tvalid[k]}};
    end
  end

  assign beatPresent = |i_PE_tvalid;
  assign beatLast    = |(i_PE_tlast & i_PE_tvalid);

  assign fifoEmpty = (occupancy == '0);
  assign fifoFull  = (occupancy == CNT_W'(FIFO_DEPTH));
  assign doPop     = !fifoEmpty && m_axis_tready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign doPush    = beatPresent && (!fifoFull || doPop);
  assign doDrop    = beatPresent && !doPush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dataMem[i] <= '0;
        keepMem[i] <= '0;
      end
      lastMem <= '0;
    end else if (doPush) begin
      dataMem[wrPtr] <= i_PE_data;
      keepMem[wrPtr] <= beatKeep;
      lastMem[wrPtr] <= beatLast;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occupancy <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign m_axis_tvalid = !fifoEmpty;
  assign m_axis_tdata  = dataMem[rdPtr];
  assign m_axis_tkeep  = keepMem[rdPtr];
  assign m_axis_tlast  = lastMem[rdPtr];

  // A drop wins over a simultaneous clear so no lost beat goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow <= 1'b0;
    end else if (doDrop) begin
      o_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (doPush) begin
      nextState = beatLast ? IDLE : PKT;
    end
  end

`ifdef PE_SINK_STATS_EN
  logic        firstBeat;
  logic [15:0] pktCnt;
  logic [15:0] beatCnt;

  always_comb begin
    firstBeat = 1'b0;
    if (state == IDLE) begin
      firstBeat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pktCnt  <= '0;
      beatCnt <= '0;
    end else if (doPush) begin
      if (firstBeat) begin
        beatCnt <= 16'd1;
      end else if (beatCnt != 16'hFFFF) begin
        beatCnt <= beatCnt + 16'd1;
      end
      if (beatLast && (pktCnt != 16'hFFFF)) begin
        pktCnt <= pktCnt + 16'd1;
      end
    end
  end

  assign o_pkt_cnt  = pktCnt;
  assign o_beat_cnt = beatCnt;
`else
  assign o_pkt_cnt  = 16'h0;
  assign o_beat_cnt = 16'h0;
`endif

endmodule
